// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// Memory-access pipeline stage sitting directly behind the execute stage.
// It takes the execute stage's registered ALU result and load/store request,
// runs a single outstanding req/ack transaction on the data-memory bus (any
// number of wait states), holds the pipeline with `stall` while that
// transaction is outstanding, and presents one registered writeback result.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a bus access that has not
// been acknowledged within TIMEOUT_CYCLES busy cycles (reported on mem_err).
// Without the macro the stage waits for dmem_ack indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  busy cycles without ack before abort (MEM_TIMEOUT_EN only)
//   RD_IDX_W        width of the destination register index
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   ex_*            execute-stage outputs: ALU result/valid, dest index,
//                   byte address, load/store byte enables, store data
//   stall           high while a bus access is outstanding
//   dmem_*          data-memory bus: registered req/we/be/addr/wdata out,
//                   single-cycle ack and read data in
//   wb_*            one-cycle writeback strobe, register index and data
//   mem_err         one-cycle pulse for misaligned/illegal access or timeout
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RD_IDX_W       = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_x_rd_vld,
    input  logic [31:0]         ex_x_rd,
    input  logic [RD_IDX_W-1:0] ex_rd_idx,
    input  logic [31:0]         ex_memaddr,
    input  logic [3:0]          ex_memrden,
    input  logic [3:0]          ex_memwren,
    input  logic [31:0]         ex_memwrdata,
    output logic                stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [3:0]          dmem_be,
    output logic [31:0]         dmem_addr,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic                wb_vld,
    output logic [RD_IDX_W-1:0] wb_rd_idx,
    output logic [31:0]         wb_data,
    output logic                mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic                  dmem_req_reg, dmem_req_next;
    logic                  dmem_we_reg, dmem_we_next;
    logic [3:0]            dmem_be_reg, dmem_be_next;
    logic [31:0]           dmem_addr_reg, dmem_addr_next;
    logic [31:0]           dmem_wdata_reg, dmem_wdata_next;
    logic                  wb_vld_reg, wb_vld_next;
    logic [RD_IDX_W-1:0]   wb_rd_idx_reg, wb_rd_idx_next;
    logic [31:0]           wb_data_reg, wb_data_next;
    logic                  mem_err_reg, mem_err_next;
    logic [RD_IDX_W-1:0]   ld_idx_reg, ld_idx_next;

    // ------------------------------------------------------------------
    // Request decode (only meaningful while IDLE)
    // ------------------------------------------------------------------
    logic rd_any, wr_any;
    logic rd_full, wr_full;
    logic en_illegal, misaligned, acc_err;

    assign rd_any  = |ex_memrden;
    assign wr_any  = |ex_memwren;
    assign rd_full = (ex_memrden == 4'b1111);
    assign wr_full = (ex_memwren == 4'b1111);

    // Only full-word accesses are supported; partial enables or a combined
    // read+write are rejected rather than silently truncated.
    assign en_illegal = (rd_any && wr_any)
                      || (rd_any && !rd_full)
                      || (wr_any && !wr_full);
    assign misaligned = (rd_any || wr_any) && (ex_memaddr[1:0] != 2'b00);
    assign acc_err    = en_illegal || misaligned;

    // ------------------------------------------------------------------
    // Optional bus timeout
    // ------------------------------------------------------------------
    logic tmo_hit;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;

    // The counter holds the number of earlier un-acked BUSY cycles, so the
    // current cycle is the TIMEOUT_CYCLES-th one when it equals limit-1.
    assign tmo_hit = (state_reg == BUSY) && !dmem_ack
                   && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_next = tmo_cnt_reg;
        if (state_reg == IDLE) begin
            tmo_cnt_next = '0;
        end else if (!dmem_ack) begin
            tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        dmem_req_next   = dmem_req_reg;
        dmem_we_next    = dmem_we_reg;
        dmem_be_next    = dmem_be_reg;
        dmem_addr_next  = dmem_addr_reg;
        dmem_wdata_next = dmem_wdata_reg;
        wb_vld_next     = 1'b0;
        wb_rd_idx_next  = wb_rd_idx_reg;
        wb_data_next    = wb_data_reg;
        mem_err_next    = 1'b0;
        ld_idx_next     = ld_idx_reg;

        case (state_reg)
            IDLE: begin
                if (acc_err) begin
                    mem_err_next = 1'b1;
                end else if (rd_full) begin
                    // A load takes priority over any ALU result presented
                    // alongside it.
                    state_next     = BUSY;
                    dmem_req_next  = 1'b1;
                    dmem_we_next   = 1'b0;
                    dmem_be_next   = 4'b1111;
                    dmem_addr_next = {ex_memaddr[31:2], 2'b00};
                    ld_idx_next    = ex_rd_idx;
                end else if (wr_full) begin
                    state_next      = BUSY;
                    dmem_req_next   = 1'b1;
                    dmem_we_next    = 1'b1;
                    dmem_be_next    = 4'b1111;
                    dmem_addr_next  = {ex_memaddr[31:2], 2'b00};
                    dmem_wdata_next = ex_memwrdata;
                end else if (ex_x_rd_vld) begin
                    wb_vld_next    = 1'b1;
                    wb_rd_idx_next = ex_rd_idx;
                    wb_data_next   = ex_x_rd;
                end
            end

            BUSY: begin
                // Bus fields are simply not updated here, which keeps them
                // stable for the whole request.
                if (dmem_ack) begin
                    state_next    = IDLE;
                    dmem_req_next = 1'b0;
                    if (!dmem_we_reg) begin
                        wb_vld_next    = 1'b1;
                        wb_rd_idx_next = ld_idx_reg;
                        wb_data_next   = dmem_rdata;
                    end
                end else if (tmo_hit) begin
                    state_next    = IDLE;
                    dmem_req_next = 1'b0;
                    mem_err_next  = 1'b1;
                end
            end

            default: begin
                state_next    = IDLE;
                dmem_req_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_be_reg    <= 4'b0000;
            dmem_addr_reg  <= 32'h0;
            dmem_wdata_reg <= 32'h0;
            wb_vld_reg     <= 1'b0;
            wb_rd_idx_reg  <= '0;
            wb_data_reg    <= 32'h0;
            mem_err_reg    <= 1'b0;
            ld_idx_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            dmem_req_reg   <= dmem_req_next;
            dmem_we_reg    <= dmem_we_next;
            dmem_be_reg    <= dmem_be_next;
            dmem_addr_reg  <= dmem_addr_next;
            dmem_wdata_reg <= dmem_wdata_next;
            wb_vld_reg     <= wb_vld_next;
            wb_rd_idx_reg  <= wb_rd_idx_next;
            wb_data_reg    <= wb_data_next;
            mem_err_reg    <= mem_err_next;
            ld_idx_reg     <= ld_idx_next;
        end
    end

    assign stall      = (state_reg == BUSY);
    assign dmem_req   = dmem_req_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_be    = dmem_be_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_wdata = dmem_wdata_reg;
    assign wb_vld     = wb_vld_reg;
    assign wb_rd_idx  = wb_rd_idx_reg;
    assign wb_data    = wb_data_reg;
    assign mem_err    = mem_err_reg;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//
// Scoreboard bench for mem_access. Stimulus tasks push the expected writeback
// / error events and expected bus requests into queues; an independent
// monitor on the falling clock edge pops and compares whenever the DUT
// presents wb_vld, mem_err or dmem_req.
// -----------------------------------------------------------------------------
module tb_mem_access;

    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ex_x_rd_vld = 1'b0;
    logic [31:0]      ex_x_rd = 32'h0;
    logic [IDX_W-1:0] ex_rd_idx = '0;
    logic [31:0]      ex_memaddr = 32'h0;
    logic [3:0]       ex_memrden = 4'h0;
    logic [3:0]       ex_memwren = 4'h0;
    logic [31:0]      ex_memwrdata = 32'h0;
    logic             stall;
    logic             dmem_req;
    logic             dmem_we;
    logic [3:0]       dmem_be;
    logic [31:0]      dmem_addr;
    logic [31:0]      dmem_wdata;
    logic             dmem_ack = 1'b0;
    logic [31:0]      dmem_rdata = 32'h0;
    logic             wb_vld;
    logic [IDX_W-1:0] wb_rd_idx;
    logic [31:0]      wb_data;
    logic             mem_err;

    always #5 clk = ~clk;

    mem_access #(
        .TIMEOUT_CYCLES(4),
        .RD_IDX_W      (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_x_rd_vld (ex_x_rd_vld),
        .ex_x_rd     (ex_x_rd),
        .ex_rd_idx   (ex_rd_idx),
        .ex_memaddr  (ex_memaddr),
        .ex_memrden  (ex_memrden),
        .ex_memwren  (ex_memwren),
        .ex_memwrdata(ex_memwrdata),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .wb_vld      (wb_vld),
        .wb_rd_idx   (wb_rd_idx),
        .wb_data     (wb_data),
        .mem_err     (mem_err)
    );

    typedef struct packed {
        logic             is_err;
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } wb_exp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;

    // ------------------------------------------------------------------
    // Monitor: compare DUT outputs against queued expectations
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (stall) stall_cycles++;

            if (wb_vld || mem_err) begin
                checks++;
                if (wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got wb_vld=%0b mem_err=%0b idx=%0d data=%h, required no event",
                             wb_vld, mem_err, wb_rd_idx, wb_data);
                end else begin
                    wb_exp_t e;
                    logic ok;
                    e = wb_q.pop_front();
                    if (e.is_err) ok = mem_err && !wb_vld;
                    else ok = wb_vld && !mem_err && (wb_data == e.data) && (wb_rd_idx == e.idx);
                    if (!ok) begin
                        errors++;
                        $display("FAIL wb_event: got vld=%0b err=%0b idx=%0d data=%h, required err=%0b idx=%0d data=%h",
                                 wb_vld, mem_err, wb_rd_idx, wb_data, e.is_err, e.idx, e.data);
                    end else if (e.is_err) begin
                        $display("t=%0t mem_err pulse", $time);
                    end else begin
                        $display("t=%0t writeback idx=%0d data=%h", $time, wb_rd_idx, wb_data);
                    end
                end
            end

            if (dmem_req) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got req we=%0b addr=%h, required no request",
                             dmem_we, dmem_addr);
                end else begin
                    bus_exp_t b;
                    b = bus_q[0];
                    if (dmem_we !== b.we || dmem_be !== b.be || dmem_addr !== b.addr ||
                        (b.we && dmem_wdata !== b.wdata)) begin
                        errors++;
                        $display("FAIL bus_fields: got we=%0b be=%h addr=%h wdata=%h, required we=%0b be=%h addr=%h wdata=%h",
                                 dmem_we, dmem_be, dmem_addr, dmem_wdata, b.we, b.be, b.addr, b.wdata);
                    end
                    if (dmem_ack) begin
                        void'(bus_q.pop_front());
                        $display("t=%0t bus %s addr=%h done", $time, dmem_we ? "write" : "read", dmem_addr);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic vld, input logic [31:0] xrd, input logic [IDX_W-1:0] idx,
                         input logic [31:0] addr, input logic [3:0] rden, input logic [3:0] wren,
                         input logic [31:0] wdata);
        ex_x_rd_vld  = vld;
        ex_x_rd      = xrd;
        ex_rd_idx    = idx;
        ex_memaddr   = addr;
        ex_memrden   = rden;
        ex_memwren   = wren;
        ex_memwrdata = wdata;
        @(posedge clk);
        #1;
        ex_x_rd_vld  = 1'b0;
        ex_x_rd      = 32'h0;
        ex_rd_idx    = '0;
        ex_memaddr   = 32'h0;
        ex_memrden   = 4'h0;
        ex_memwren   = 4'h0;
        ex_memwrdata = 32'h0;
    endtask

    // Ack arrives in the k-th request cycle (k >= 1); called right after issue.
    task automatic ack_after(input int k, input logic [31:0] rdata);
        repeat (k - 1) begin
            @(posedge clk);
            #1;
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && wb_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_pending_events"}, wb_q.size(), 0);
    endtask

    function automatic wb_exp_t wbe(input logic is_err, input logic [IDX_W-1:0] idx, input logic [31:0] data);
        wb_exp_t e;
        e.is_err = is_err;
        e.idx    = idx;
        e.data   = data;
        return e;
    endfunction

    function automatic bus_exp_t buse(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_exp_t b;
        b.we    = we;
        b.be    = 4'hF;
        b.addr  = addr;
        b.wdata = wdata;
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   dmem_req,   0);
        chk("rst_stall", stall,      0);
        chk("rst_we",    dmem_we,    0);
        chk("rst_be",    dmem_be,    0);
        chk("rst_addr",  dmem_addr,  0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb",    {wb_vld, mem_err, wb_rd_idx}, 0);
        chk("rst_wbdat", wb_data,    0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU passthrough
        stall_cycles = 0;
        wb_q.push_back(wbe(1'b0, 5, 32'h0000_0123));
        issue(1'b1, 32'h0000_0123, 5, 32'h0, 4'h0, 4'h0, 32'h0);
        drain("alu");
        chk("alu_stall", stall_cycles, 0);

        // LW, ack in third request cycle
        stall_cycles = 0;
        bus_q.push_back(buse(1'b0, 32'h0000_0040, 32'h0));
        wb_q.push_back(wbe(1'b0, 7, 32'hDEAD_BEEF));
        issue(1'b0, 32'h0, 7, 32'h0000_0040, 4'hF, 4'h0, 32'h0);
        ack_after(3, 32'hDEAD_BEEF);
        drain("lw3");
        chk("lw3_stall", stall_cycles, 3);

        // SW, ack in first request cycle, no writeback
        stall_cycles = 0;
        bus_q.push_back(buse(1'b1, 32'h0000_0044, 32'h1234_5678));
        issue(1'b0, 32'h0, 0, 32'h0000_0044, 4'h0, 4'hF, 32'h1234_5678);
        ack_after(1, 32'hFFFF_FFFF);
        drain("sw1");
        chk("sw1_stall", stall_cycles, 1);

        // Misaligned load
        stall_cycles = 0;
        wb_q.push_back(wbe(1'b1, 0, 32'h0));
        issue(1'b0, 32'h0, 2, 32'h0000_0042, 4'hF, 4'h0, 32'h0);
        drain("misalign");
        chk("misalign_stall", stall_cycles, 0);

        // Both enables set
        wb_q.push_back(wbe(1'b1, 0, 32'h0));
        issue(1'b0, 32'h0, 3, 32'h0000_0048, 4'hF, 4'hF, 32'h0);
        drain("rdwr");

        // Partial byte enable is illegal
        wb_q.push_back(wbe(1'b1, 0, 32'h0));
        issue(1'b1, 32'h77, 4, 32'h0000_0050, 4'h3, 4'h0, 32'h0);
        drain("partial");
        chk("err_stall", stall_cycles, 0);

        // Load with ALU valid: load result wins
        bus_q.push_back(buse(1'b0, 32'h0000_0080, 32'h0));
        wb_q.push_back(wbe(1'b0, 3, 32'hCAFE_F00D));
        issue(1'b1, 32'h0000_0111, 3, 32'h0000_0080, 4'hF, 4'h0, 32'h0);
        ack_after(2, 32'hCAFE_F00D);
        drain("ld_alu");

        // Back-to-back loads, second sampled as state returns to IDLE
        stall_cycles = 0;
        bus_q.push_back(buse(1'b0, 32'h0000_0100, 32'h0));
        bus_q.push_back(buse(1'b0, 32'h0000_0104, 32'h0));
        wb_q.push_back(wbe(1'b0, 9, 32'h0BAD_0001));
        wb_q.push_back(wbe(1'b0, 11, 32'h0BAD_0002));
        issue(1'b0, 32'h0, 9, 32'h0000_0100, 4'hF, 4'h0, 32'h0);
        ack_after(1, 32'h0BAD_0001);
        issue(1'b0, 32'h0, 11, 32'h0000_0104, 4'hF, 4'h0, 32'h0);
        chk("b2b_req", dmem_req, 1);
        ack_after(1, 32'h0BAD_0002);
        drain("b2b");
        chk("b2b_stall", stall_cycles, 2);

        // Stray ack while IDLE
        stall_cycles = 0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drain("idle_ack");
        chk("idle_ack_stall", stall_cycles, 0);

        // Reset in the middle of a load; late ack afterwards
        bus_q.push_back(buse(1'b0, 32'h0000_0200, 32'h0));
        issue(1'b0, 32'h0, 12, 32'h0000_0200, 4'hF, 4'h0, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_req",   dmem_req, 0);
        chk("midrst_stall", stall,    0);
        bus_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drain("late_ack");
        chk("late_ack_req", {dmem_req, stall}, 0);

`ifdef MEM_TIMEOUT_EN
        // Load that is never acknowledged: abort after 4 BUSY cycles
        stall_cycles = 0;
        bus_q.push_back(buse(1'b0, 32'h0000_0300, 32'h0));
        wb_q.push_back(wbe(1'b1, 0, 32'h0));
        issue(1'b0, 32'h0, 13, 32'h0000_0300, 4'hF, 4'h0, 32'h0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("tmo_req", dmem_req, 0);
        bus_q.delete();
        drain("timeout");
        chk("tmo_stall", stall_cycles, 4);
`endif

        chk("bus_pending", bus_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
